// File: rtl/candgen_pkg.sv
// Shared types and defaults for the MD5 candidate generator.
package candgen_pkg;
   localparam int BLK_W_DEF = 512;
   localparam int SYM_W_DEF = 8;
   localparam int LEN_W_DEF = 64;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   function automatic int pay_w(input int blk_w, input int len_w);
      return blk_w - len_w;
   endfunction
endpackage

// File: rtl/candgen_lane.sv
// One lane: appends a symbol to the prefix payload and advances the bit-length field.
module candgen_lane
   import candgen_pkg::*;
#(
   parameter int BLK_W = BLK_W_DEF,
   parameter int SYM_W = SYM_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic [BLK_W-1:0] blk,
   input  logic [SYM_W-1:0] sym,
   output logic [BLK_W-1:0] new_blk
);
   localparam int PAY_W = pay_w(BLK_W, LEN_W);

   logic [LEN_W-1:0] len;
   logic             unused_top;

   // Length wraps modulo 2^LEN_W; the oldest SYM_W payload bits fall off the top.
   assign len        = blk[BLK_W-1 -: LEN_W] + LEN_W'(SYM_W);
   assign unused_top = ^blk[PAY_W-1 -: SYM_W];
   assign new_blk    = {len, blk[PAY_W-SYM_W-1:0], sym};
endmodule

// File: rtl/candidate_gen.sv
// Emits LANES prefix+symbol candidates per beat over [from_num, to_num].
// Optional CANDGEN_PERF_CNT_EN adds a saturating delivered-candidate counter.
module candidate_gen
   import candgen_pkg::*;
#(
   parameter int BLK_W = BLK_W_DEF,
   parameter int SYM_W = SYM_W_DEF,
   parameter int LEN_W = LEN_W_DEF,
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   restart,
   input  logic                   start,
   input  logic [BLK_W-1:0]       old_string,
   input  logic [SYM_W-1:0]       from_num,
   input  logic [SYM_W-1:0]       to_num,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*BLK_W-1:0] out_data,
   output logic [LANES-1:0]       out_mask,
   output logic                   out_last,
`ifdef CANDGEN_PERF_CNT_EN
   output logic [31:0]            cand_count,
`endif
   output logic                   busy,
   output logic                   done
);
   localparam logic [SYM_W:0] LANES_C = (SYM_W+1)'(LANES);

   state_t                         state;
   logic [SYM_W:0]                 cnt;
   logic [SYM_W-1:0]               to_q;
   logic [BLK_W-1:0]               blk_q;
   logic [LANES-1:0][BLK_W-1:0]    lane_blk;
   logic [LANES-1:0][BLK_W-1:0]    beat_data;
   logic [LANES-1:0]               beat_mask;
   logic [SYM_W:0]                 cnt_nxt;
   logic                           final_beat;
   logic                           load;

   // One extra counter bit so to_num = 2^SYM_W-1 terminates instead of wrapping.
   assign cnt_nxt    = cnt + LANES_C;
   assign final_beat = cnt_nxt > {1'b0, to_q};
   assign load       = !out_valid || out_ready;

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         logic [SYM_W:0] num;
         assign num = cnt + (SYM_W+1)'(i);
         candgen_lane #(.BLK_W(BLK_W), .SYM_W(SYM_W), .LEN_W(LEN_W)) u_lane (
            .blk     (blk_q),
            .sym     (num[SYM_W-1:0]),
            .new_blk (lane_blk[i])
         );
         assign beat_mask[i] = num <= {1'b0, to_q};
         assign beat_data[i] = beat_mask[i] ? lane_blk[i] : '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         to_q      <= '0;
         blk_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_mask  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (restart) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_mask  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               blk_q <= old_string;
               to_q  <= to_num;
               cnt   <= {1'b0, from_num};
               busy  <= 1'b1;
               state <= (from_num > to_num) ? DONE : RUN;
            end
            RUN: if (load) begin
               out_valid <= 1'b1;
               out_data  <= beat_data;
               out_mask  <= beat_mask;
               cnt       <= cnt_nxt;
               if (final_beat) begin
                  out_last <= 1'b1;
                  state    <= DRAIN;
               end
            end
            DRAIN: if (out_ready) begin
               out_valid <= 1'b0;
               out_mask  <= '0;
               out_last  <= 1'b0;
               state     <= DONE;
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CANDGEN_PERF_CNT_EN
   logic [31:0] pop;
   logic [32:0] sum;

   always_comb begin
      pop = '0;
      for (int i = 0; i < LANES; i++) pop = pop + 32'(out_mask[i]);
   end
   assign sum = {1'b0, cand_count} + {1'b0, pop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cand_count <= '0;
      else if (start && state == IDLE && !restart)
         cand_count <= '0;
      else if (out_valid && out_ready)
         cand_count <= sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   end
`endif
endmodule
